or2t_merge_scheduler: RTL
=========================

Name: or2t_merge_scheduler

Overview:
- Sequencing controller for a clocked two-input pulse merger (OR2T-type cell) that is shared between N_REQ requesters.
- Each requester pulse is turned into exactly one cell data pulse, on input a or b, followed by one cell clock pulse.
- A cell output toggle confirms each pulse, so simultaneous requests are serialized and not merged (lost).
- All pulse lines are toggle-encoded: one transition (either edge) = one pulse.

Parameters:
- N_REQ, 4: number of requesters (≥2).
- CNT_W, 4: width of each pending-pulse counter; saturates at 2^CNT_W-1.
- HOLD_CYC, 2: clk cycles from the data toggle to the cell_clk toggle (≥1). Enforces the cell's data-to-clock hold window.
- TIMEOUT_CYC, 4: clk cycles allowed after the cell_clk toggle for a cell_q toggle (≥1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_t  in  N_REQ  toggle-encoded request pulses, one bit per requester.
- cell_a  out  1  toggle-encoded data pulse to cell input a (even requester indices).
- cell_b  out  1  toggle-encoded data pulse to cell input b (odd requester indices).
- cell_clk  out  1  toggle-encoded clock pulse to the cell.
- cell_q  in  1  toggle-encoded cell output.
- grant_vld  out  1  one-cycle strobe: pulse confirmed.
- grant_id  out  ID_W  requester served. ID_W = max(1, clog2(N_REQ)); valid only with grant_vld.
- pending_any  out  1  some counter nonzero, or FSM not IDLE.
- overflow  out  N_REQ  sticky: a pulse was dropped at saturation.
- err_timeout  out  1  sticky: no cell_q toggle within TIMEOUT_CYC.
- err_spurious  out  1  sticky: cell_q toggled outside WAIT_Q.

Behaviour:
- Reset, while rst=1 at an edge:
  - all outputs and counters = 0; FSM = IDLE; round-robin pointer = 0.
  - req_prev <= req_t and q_prev <= cell_q, so no pulse is inferred from pre-reset levels.
  - Reset mid-operation aborts the service in progress silently (no grant, no error). Cell output lines return to level 0; the cell must be reset alongside.
- Pulse detect: pulse[i] = req_t[i] ^ req_prev[i], evaluated at each edge; q_pulse = cell_q ^ q_prev.
- Pending counter per requester:
  - +1 on pulse; -1 when selected.
  - Increment and decrement in the same cycle: counter unchanged.
  - Increment at saturation without a decrement: count holds and overflow[i] sets.
- Arbitration (in IDLE):
  - winner = first index with count>0, searching from ptr upward with wrap.
  - Afterwards ptr = (winner+1) mod N_REQ.
  - A pulse arriving at edge k is eligible from edge k+1.
- FSM:
  - IDLE: if any count>0, latch winner, decrement its count, toggle cell_a (winner even) or cell_b (winner odd); gap = HOLD_CYC-1 -> HOLD. Otherwise stay.
  - HOLD: if gap=0, toggle cell_clk, tmo = TIMEOUT_CYC-1 -> WAIT_Q; else gap-1. The cell_clk toggle occurs exactly HOLD_CYC edges after the data toggle.
  - WAIT_Q: if q_pulse, grant_vld=1 and grant_id=winner for one cycle -> IDLE. Else if tmo=0, set err_timeout -> IDLE with no grant. Else tmo-1.
- Service period per pulse ≥ HOLD_CYC+2 cycles; a new service begins only in IDLE.
- q_pulse in IDLE or HOLD sets err_spurious and is otherwise ignored.
- Only one of cell_a/cell_b/cell_clk toggles in any cycle.
- Sticky flags clear only on rst.

Optional Feature:
- Macro: OR2T_SCHED_STRICT_PRIO_EN.
- Defined: winner = lowest index with count>0; ptr unused (held at 0).
- Undefined: round-robin as above.

Test Plan:
- Reset: rst=1 for 2 cycles with req_t=4'b1010, then rst=0 with req_t held -> no data or clock toggles, all flags 0, pending_any=0 for 20 cycles.
- Single request: HOLD_CYC=2; cell model toggles cell_q 1 cycle after cell_clk. req_t[2] toggles, first sampled at edge k:
  - cell_a toggles at edge k+1;
  - cell_clk toggles at edge k+3;
  - grant_vld=1 with grant_id=2 one cycle after the cell_q toggle;
  - cell_b never toggles.
- Simultaneous: req_t goes 0000->1111 in one cycle -> 4 grants, ids 0,1,2,3 in order. cell_a toggles twice, cell_b twice, cell_clk 4 times.
- Saturation: CNT_W=2, cell_q tied constant, req_t[1] toggles on 5 consecutive edges -> overflow[1]=1, overflow[0,2,3]=0, err_timeout=1 after the first service, no grant_vld.
- Timeout recovery: cell_q stuck, then a responsive model connected. Two pulses on req 0 ->
  - first: err_timeout set TIMEOUT_CYC cycles after cell_clk, no grant;
  - second: served with grant_vld, id 0.
  - cell_q toggled while IDLE -> err_spurious=1.
- Priority: req 3 pending, then req 0 and req 3 pulse together.
  - Default build: grants alternate 0 and 3 per pointer.
  - OR2T_SCHED_STRICT_PRIO_EN build: all pending req 0 pulses are served before any req 3.

Source files
------------

// File: rtl/or2t_merge_scheduler.sv
// ----------------------------------------------------------------------------
// or2t_merge_scheduler
//
// Sequencing controller for a clocked two-input pulse merger (OR2T-type cell)
// that is shared between N_REQ requesters. Each request pulse becomes one data
// pulse on cell input a (even requester) or b (odd requester), followed
// HOLD_CYC cycles later by one cell clock pulse. A toggle on cell_q confirms
// the pulse. Simultaneous requests are queued in per-requester counters and
// serialized, so no pulse is merged into another. All pulse lines are
// toggle-encoded: one transition of either polarity is one pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_t        toggle-encoded request pulses, one bit per requester
//   cell_a       toggle-encoded data pulse to cell input a (even requesters)
//   cell_b       toggle-encoded data pulse to cell input b (odd requesters)
//   cell_clk     toggle-encoded clock pulse to the cell
//   cell_q       toggle-encoded cell output
//   grant_vld    one-cycle strobe: pulse confirmed by cell_q
//   grant_id     requester served, valid with grant_vld
//   pending_any  some counter nonzero or a service in progress
//   overflow     sticky per requester: pulse dropped at counter saturation
//   err_timeout  sticky: no cell_q toggle within TIMEOUT_CYC after cell_clk
//   err_spurious sticky: cell_q toggled outside the wait-for-q window
//
// Build option:
//   OR2T_SCHED_STRICT_PRIO_EN  defined: lowest pending index always wins
//                              undefined: round-robin from a rotating pointer
// ----------------------------------------------------------------------------
module or2t_merge_scheduler #(
  parameter int N_REQ       = 4,
  parameter int CNT_W       = 4,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 4,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_t,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_clk,
  input  logic             cell_q,
  output logic             grant_vld,
  output logic [ID_W-1:0]  grant_id,
  output logic             pending_any,
  output logic [N_REQ-1:0] overflow,
  output logic             err_timeout,
  output logic             err_spurious
);

  localparam int unsigned NQ    = N_REQ;
  localparam int          GAP_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int          TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_Q
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] req_prev;
  logic             q_prev;
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic [GAP_W-1:0] gap;
  logic [TMO_W-1:0] tmo;

  logic [N_REQ-1:0] pulse;
  logic             q_pulse;
  logic [N_REQ-1:0] nz;
  logic             found;
  logic [ID_W-1:0]  pick;
  logic [N_REQ-1:0] take;
  logic [ID_W-1:0]  ptr_next;

  assign pulse   = req_t ^ req_prev;
  assign q_pulse = cell_q ^ q_prev;

  always_comb begin
    for (int unsigned i = 0; i < NQ; i++) begin
      nz[i] = |cnt[i];
    end
  end

  // Rotating search done as two linear passes: first the indices at or above
  // ptr, then (only if none found) the lowest pending index overall, which is
  // the wrapped part of the search. With ptr held at 0 this degenerates to
  // strict lowest-index priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      if (!found && nz[i] && (ID_W'(i) >= ptr)) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NQ; i++) begin
      if (!found && nz[i]) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
  end

  always_comb begin
    take = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      if ((state == S_IDLE) && found && (pick == ID_W'(i))) begin
        take[i] = 1'b1;
      end
    end
  end

  assign ptr_next    = (pick == ID_W'(NQ - 1)) ? '0 : pick + 1'b1;
  assign pending_any = (|nz) || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_prev     <= req_t;
      q_prev       <= cell_q;
      ptr          <= '0;
      winner       <= '0;
      gap          <= '0;
      tmo          <= '0;
      cell_a       <= 1'b0;
      cell_b       <= 1'b0;
      cell_clk     <= 1'b0;
      grant_vld    <= 1'b0;
      grant_id     <= '0;
      overflow     <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      for (int unsigned i = 0; i < NQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      req_prev  <= req_t;
      q_prev    <= cell_q;
      grant_vld <= 1'b0;

      // Simultaneous increment and decrement leave the count unchanged.
      for (int unsigned i = 0; i < NQ; i++) begin
        if (pulse[i] && !take[i]) begin
          if (&cnt[i]) begin
            overflow[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else if (!pulse[i] && take[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (q_pulse) begin
            err_spurious <= 1'b1;
          end
          if (found) begin
            winner <= pick;
            if (pick[0]) begin
              cell_b <= ~cell_b;
            end else begin
              cell_a <= ~cell_a;
            end
            gap   <= GAP_W'(HOLD_CYC - 1);
            state <= S_HOLD;
`ifndef OR2T_SCHED_STRICT_PRIO_EN
            ptr   <= ptr_next;
`endif
          end
        end

        S_HOLD: begin
          if (q_pulse) begin
            err_spurious <= 1'b1;
          end
          if (gap == '0) begin
            cell_clk <= ~cell_clk;
            tmo      <= TMO_W'(TIMEOUT_CYC - 1);
            state    <= S_WAIT_Q;
          end else begin
            gap <= gap - 1'b1;
          end
        end

        S_WAIT_Q: begin
          if (q_pulse) begin
            grant_vld <= 1'b1;
            grant_id  <= winner;
            state     <= S_IDLE;
          end else if (tmo == '0) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo <= tmo - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
